mem_port_sequencer: RTL and testbench
=====================================

# mem_port_sequencer

Sequences the single byte-wide port of the unified instruction/data memory and shares it between the instruction-fetch and data (load/store) requesters. Each 32-bit access becomes four big-endian byte beats, issued most-significant byte first at byte address A+0. Sits between the SCC core's fetch/LSU and the memory array. On halt it drains the in-flight access and parks, so the memory-dump logic sees a quiescent array.

## Interface
- ADDR_W, 16: memory byte-address width. Upper bits of the 32-bit request addresses are ignored.
- mem_Clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- halt_f  in  1  core halt; level, sampled
- if_req  in  1  fetch request; level, held until if_valid
- if_addr  in  32  fetch byte address
- if_valid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched word, big-endian
- dm_req  in  1  data request; level, held until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  32  data byte address
- dm_wdata  in  32  store word
- dm_valid  out  1  one-cycle pulse: load data valid or store complete
- dm_rdata  out  32  loaded word; holds its last value after a store
- mem_en  out  1  byte-port enable
- mem_we  out  1  byte write enable
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte; synchronous, 1-cycle latency (address in cycle n, data in cycle n+1)
- halted  out  1  high once parked after halt

## Operation
- States: IDLE, ISSUE, WAIT, RESP, HALTED.
- Arbitration occurs only at the edge ending an IDLE or RESP cycle.
  - One requester active: it is granted.
  - Both active: the one not granted last time wins. last_grant resets to "fetch", so data wins the first tie.
  - In RESP, a requester still holding req is treated as a new request. Requesters drop req in the cycle their valid is high unless they want another access.
- At grant, the following are latched: addr[ADDR_W-1:0], we (fetch is always read), wdata, owner. Later input changes are ignored.
- ISSUE: 4 cycles, beat counter k = 0..3.
  - mem_en=1; mem_addr = latched addr + k, mod 2^ADDR_W (wrap-around).
  - Store: mem_we=1, mem_wdata = byte k, where byte 0 = wdata[31:24].
  - Read: the byte arriving on mem_rdata is shifted into the assembly register at each edge.
- Read path: ISSUE → WAIT (1 cycle, mem_en=0, captures the final byte) → RESP. Store path: ISSUE → RESP.
- RESP: 1 cycle. The owner's valid=1, and its rdata is updated at entry to RESP. Next state:
  - new grant → ISSUE;
  - else halt_f → HALTED;
  - else → IDLE.
- IDLE: halt_f=1 → HALTED, with priority over any requests.
- HALTED: halted=1, mem_en=0, no grants. Exited only by reset.
- Halt asserted during ISSUE/WAIT: the access completes, including its valid pulse, then the block goes to HALTED.
- Unaligned addresses are legal; no alignment check.
- Outside ISSUE: mem_en=mem_we=0, and mem_addr/mem_wdata hold their last values.

## Timing
- Reset values: if_valid, dm_valid, mem_en, mem_we, halted = 0; if_rdata, dm_rdata, mem_addr, mem_wdata = 0; state = IDLE.
- All outputs are registered.
- Cycle 0 is the cycle in which req is first high in IDLE.
  - Beats occupy cycles 1–4.
  - Load/fetch: valid in cycle 6 (6-cycle latency).
  - Store: valid in cycle 5; memory is updated by the end of cycle 4.
- Back-to-back: a request held through RESP starts its beats in the cycle immediately after RESP. No idle gap.
- Async reset mid-ISSUE aborts the access with no valid pulse. Bytes already written remain written.

## Structure
- Package mem_seq_pkg holds:
  - state enum;
  - BEATS=4;
  - OWNER_IF/OWNER_DM encoding.
- Sub-module mem_byte_lane handles byte-beat serialisation for stores and big-endian assembly for loads. Control stays in mem_port_sequencer.

## Test plan
- Fetch from 0x0000 with memory bytes 12 34 56 78 → mem_addr 0,1,2,3 in cycles 1–4; if_valid in cycle 6 with if_rdata=0x12345678.
- Store 0xDEADBEEF to 0x0420, then load from 0x0420 → write beats DE,AD,BE,EF; dm_valid in cycle 5; load returns 0xDEADBEEF.
- if_req and dm_req rise in the same cycle and stay held → data is served first, then fetch starts in the cycle after data's RESP; ties then alternate.
- Load from 0xFFFE → mem_addr FFFE, FFFF, 0000, 0001 (wrap-around).
- halt_f rises in cycle 2 of a fetch → fetch completes with if_valid in cycle 6, then halted=1; a pending dm_req is never granted.
- rst_n asserted low in cycle 3 of a store → all outputs 0 immediately, no dm_valid; after release, state is IDLE.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the byte-port memory sequencer.
package mem_seq_pkg;

    localparam int BEATS = 4;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        HALTED
    } state_t;

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-beat datapath: serialises store words MSB first and assembles
// big-endian load words from the read byte stream.
module mem_byte_lane
    import mem_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 we,
    input  logic                 step,
    input  logic [8*BEATS-1:0]   wdata,
    input  logic [7:0]           rd_byte,
    output logic [7:0]           wr_byte,
    output logic [8*BEATS-1:0]   word
);

    logic [8*BEATS-1:0] sreg;

    // One register serves both directions; only one access is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            wr_byte <= '0;
        end else if (load) begin
            sreg <= {wdata[8*BEATS-9:0], 8'h00};
            if (we) wr_byte <= wdata[8*BEATS-1 -: 8];
        end else if (step) begin
            if (we) begin
                wr_byte <= sreg[8*BEATS-1 -: 8];
                sreg    <= {sreg[8*BEATS-9:0], 8'h00};
            end else begin
                sreg <= {sreg[8*BEATS-9:0], rd_byte};
            end
        end
    end

    // The final byte arrives after the last beat; fold it in combinationally.
    assign word = {sreg[8*BEATS-9:0], rd_byte};

endmodule

// File: rtl/mem_port_sequencer.sv
// Shares the byte-wide unified memory port between fetch and data requesters,
// turning each 32-bit access into four big-endian byte beats; parks on halt.
module mem_port_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              mem_Clk,
    input  logic              rst_n,
    input  logic              halt_f,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_valid,
    output logic [31:0]       dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              halted
);

    localparam logic [1:0] LAST = 2'(BEATS - 1);

    state_t      state;
    logic [1:0]  k;
    logic        we_q;
    logic        owner;
    logic        last_grant;
    logic        halt_seen;

    logic              grant_dm;
    logic              g_own;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic              do_grant;
    logic              step;
    logic [31:0]       word;

    logic unused_addr_hi;
    assign unused_addr_hi = ^{if_addr[31:ADDR_W], dm_addr[31:ADDR_W]};

    always_comb begin
        grant_dm = dm_req && (!if_req || last_grant == OWNER_IF);
        g_own    = grant_dm ? OWNER_DM : OWNER_IF;
        g_we     = grant_dm && dm_we;
        g_addr   = grant_dm ? dm_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
        // A halt seen mid-access wins over any request pending at RESP.
        do_grant = (if_req || dm_req) &&
                   ((state == IDLE && !halt_f) || (state == RESP && !halt_seen));
        step     = (state == ISSUE) && (!we_q || k != LAST);
    end

    mem_byte_lane u_lane (
        .clk     (mem_Clk),
        .rst_n   (rst_n),
        .load    (do_grant),
        .we      (do_grant ? g_we : we_q),
        .step    (step),
        .wdata   (dm_wdata),
        .rd_byte (mem_rdata),
        .wr_byte (mem_wdata),
        .word    (word)
    );

    always_ff @(posedge mem_Clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            k          <= '0;
            we_q       <= 1'b0;
            owner      <= OWNER_IF;
            last_grant <= OWNER_IF;
            halt_seen  <= 1'b0;
            if_valid   <= 1'b0;
            dm_valid   <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            halted     <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            if (do_grant) begin
                state      <= ISSUE;
                k          <= '0;
                owner      <= g_own;
                last_grant <= g_own;
                we_q       <= g_we;
                mem_en     <= 1'b1;
                mem_we     <= g_we;
                mem_addr   <= g_addr;
            end else begin
                case (state)
                    IDLE: begin
                        if (halt_f) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        if (halt_f) halt_seen <= 1'b1;
                        if (k == LAST) begin
                            if (we_q) begin
                                state    <= RESP;
                                dm_valid <= (owner == OWNER_DM);
                                if_valid <= (owner == OWNER_IF);
                            end else begin
                                state <= WAIT;
                            end
                        end else begin
                            k        <= k + 2'd1;
                            mem_en   <= 1'b1;
                            mem_we   <= we_q;
                            mem_addr <= mem_addr + ADDR_W'(1);
                        end
                    end
                    WAIT: begin
                        if (halt_f) halt_seen <= 1'b1;
                        state <= RESP;
                        if (owner == OWNER_DM) begin
                            dm_valid <= 1'b1;
                            dm_rdata <= word;
                        end else begin
                            if_valid <= 1'b1;
                            if_rdata <= word;
                        end
                    end
                    RESP: begin
                        if (halt_seen || halt_f) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    HALTED: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer with a 64 KiB synchronous byte memory.
module tb_mem_port_sequencer;

    logic        mem_Clk = 1'b0;
    logic        rst_n;
    logic        halt_f;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        halted;

    logic [7:0]  mem [0:65535];

    int checks = 0;
    int errors = 0;

    always #5 mem_Clk = ~mem_Clk;

    mem_port_sequencer #(.ADDR_W(16)) dut (
        .mem_Clk   (mem_Clk),
        .rst_n     (rst_n),
        .halt_f    (halt_f),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_valid  (dm_valid),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .halted    (halted)
    );

    always @(posedge mem_Clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Starts at a negedge in IDLE (cycle 0); returns at a negedge in IDLE.
    task automatic do_access(input string tag, input bit dm, input bit we,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] exp);
        int lat;
        logic [15:0] ea;
        logic [31:0] sh;
        lat = we ? 5 : 6;
        if (dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int j = 1; j <= lat; j++) begin
            @(negedge mem_Clk);
            if (j <= 4) begin
                ea = addr[15:0] + 16'(j - 1);
                chk({tag, "_beat"}, {mem_en, mem_we, mem_addr}, {1'b1, we, ea});
                if (we) begin
                    sh = wd >> (8 * (4 - j));
                    chk({tag, "_wbyte"}, mem_wdata, sh[7:0]);
                end
            end else if (j < lat) begin
                chk({tag, "_gap"}, {mem_en, if_valid, dm_valid}, 3'b000);
            end else begin
                chk({tag, "_valid"}, {if_valid, dm_valid}, dm ? 2'b01 : 2'b10);
                if (!we) chk({tag, "_rdata"}, dm ? dm_rdata : if_rdata, exp);
                if_req = 1'b0;
                dm_req = 1'b0;
            end
        end
        @(negedge mem_Clk);
        chk({tag, "_pulse"}, {if_valid, dm_valid, mem_en}, 3'b000);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; halt_f = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
        mem[16'hFFFE] = 8'hA1; mem[16'hFFFF] = 8'hB2;

        #1;
        chk("rst_ctl", {if_valid, dm_valid, mem_en, mem_we, halted}, 5'b0);
        chk("rst_if", if_rdata, 32'h0);
        chk("rst_dm", dm_rdata, 32'h0);
        chk("rst_mem", {mem_addr, mem_wdata}, 24'h0);
        repeat (2) @(negedge mem_Clk);
        rst_n = 1'b1;
        @(negedge mem_Clk);

        do_access("fetch0", 1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h1234_5678);
        do_access("store", 1'b1, 1'b1, 32'h0000_0420, 32'hDEAD_BEEF, 32'h0);
        chk("store_mem", {mem[16'h420], mem[16'h421], mem[16'h422], mem[16'h423]}, 32'hDEAD_BEEF);
        chk("store_dm_hold", dm_rdata, 32'h0);
        do_access("load", 1'b1, 1'b0, 32'h0000_0420, 32'h0, 32'hDEAD_BEEF);
        do_access("wrap", 1'b1, 1'b0, 32'hABCD_FFFE, 32'h0, 32'hA1B2_1234);

        // Store aborted by reset in cycle 3: first two bytes already written.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hCAFE_F00D;
        repeat (3) @(negedge mem_Clk);
        rst_n = 1'b0;
        dm_req = 1'b0;
        #1;
        chk("arst_ctl", {if_valid, dm_valid, mem_en, mem_we, halted}, 5'b0);
        chk("arst_data", {mem_addr, mem_wdata}, 24'h0);
        seen = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge mem_Clk);
            if (dm_valid) seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge mem_Clk);
            if (dm_valid || mem_en) seen = 1'b1;
        end
        chk("arst_no_valid", {31'h0, seen}, 32'h0);
        chk("arst_mem", {mem[16'h100], mem[16'h101], mem[16'h102]}, 24'hCAFE00);

        // Tie right after reset: data first, then back-to-back fetch, then data again.
        if_req = 1'b1; if_addr = 32'h0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h420;
        for (int j = 1; j <= 18; j++) begin
            @(negedge mem_Clk);
            case (j)
                1:  chk("tie_dm_first", {mem_en, mem_addr}, {1'b1, 16'h0420});
                6: begin
                    chk("tie_dm_valid", {if_valid, dm_valid}, 2'b01);
                    chk("tie_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
                    dm_req = 1'b0;
                end
                7:  chk("b2b_fetch", {mem_en, mem_addr}, {1'b1, 16'h0000});
                12: begin
                    chk("tie_if_valid", {if_valid, dm_valid}, 2'b10);
                    chk("tie_if_rdata", if_rdata, 32'h1234_5678);
                    dm_req = 1'b1;
                end
                13: chk("tie_alt_dm", {mem_en, mem_addr}, {1'b1, 16'h0420});
                18: begin
                    chk("tie_alt_valid", {if_valid, dm_valid}, 2'b01);
                    if_req = 1'b0;
                    dm_req = 1'b0;
                end
                default: ;
            endcase
        end
        repeat (2) @(negedge mem_Clk);
        chk("tie_idle", {mem_en, if_valid, dm_valid}, 3'b000);

        // Halt mid-fetch: fetch completes, then park with a data request pending.
        if_req = 1'b1; if_addr = 32'h0;
        seen = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge mem_Clk);
            if (j == 2) begin
                halt_f = 1'b1;
                dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h420;
            end
            if (j == 5) chk("halt_pre", {halted, if_valid}, 2'b00);
            if (j == 6) begin
                chk("halt_if_valid", {if_valid, halted}, 2'b10);
                chk("halt_if_rdata", if_rdata, 32'h1234_5678);
                if_req = 1'b0;
            end
            if (j == 7) chk("halted", {31'h0, halted}, 32'h1);
            if (j >= 7 && (mem_en || dm_valid || if_valid || !halted)) seen = 1'b1;
        end
        chk("halt_no_grant", {31'h0, seen}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
